// File: rtl/bit_pix_pkg.sv
// rtl/bit_pix_pkg.sv - shared geometry constants, third encoding and FSM type for the bit-pixel row packer
package bit_pix_pkg;

  localparam int DEF_THIRD_WIDTH  = 240;
  localparam int DEF_CENTER_WIDTH = 304;
  localparam int DEF_IMG_HEIGHT   = 480;

  function automatic int calc_row_w(input int third_w, input int center_w);
    return 2 * third_w + center_w;
  endfunction

  // Words per section per frame; also the ping-pong offset of buffer 1.
  function automatic int calc_end_addr(input int width, input int height);
    return (width * height) / 16;
  endfunction

  localparam int ROW_W = calc_row_w(DEF_THIRD_WIDTH, DEF_CENTER_WIDTH);
  localparam int TEND  = calc_end_addr(DEF_THIRD_WIDTH, DEF_IMG_HEIGHT);
  localparam int CEND  = calc_end_addr(DEF_CENTER_WIDTH, DEF_IMG_HEIGHT);

  localparam logic [1:0] THIRD_LEFT   = 2'd0;
  localparam logic [1:0] THIRD_CENTER = 2'd1;
  localparam logic [1:0] THIRD_RIGHT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pack_state_e;

endpackage

// File: rtl/bit_pix_addr_gen.sv
// rtl/bit_pix_addr_gen.sv - maps (col, row, buf_idx) of a completed word to a registered (third, BRAM address)
module bit_pix_addr_gen
  import bit_pix_pkg::*;
#(
  parameter int THIRD_WIDTH  = DEF_THIRD_WIDTH,
  parameter int CENTER_WIDTH = DEF_CENTER_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int ADDR_W       = 16,
  parameter int COL_W        = 10,
  parameter int ROW_BITS     = 9
) (
  input  logic                clk50,
  input  logic                reset,
  input  logic                load_i,
  input  logic [COL_W-1:0]    col_i,
  input  logic [ROW_BITS-1:0] row_i,
  input  logic                buf_idx_i,
  output logic [1:0]          third_o,
  output logic [ADDR_W-1:0]   address_o
);

  localparam logic [COL_W-1:0]  CENTER_START = COL_W'(THIRD_WIDTH);
  localparam logic [COL_W-1:0]  RIGHT_START  = COL_W'(THIRD_WIDTH + CENTER_WIDTH);
  localparam logic [ADDR_W-1:0] THIRD_WORDS  = ADDR_W'(THIRD_WIDTH / 16);
  localparam logic [ADDR_W-1:0] CENTER_WORDS = ADDR_W'(CENTER_WIDTH / 16);
  localparam logic [ADDR_W-1:0] RIGHT_WORD0  = ADDR_W'((THIRD_WIDTH + CENTER_WIDTH) / 16);
  localparam logic [ADDR_W-1:0] TEND_A       = ADDR_W'(calc_end_addr(THIRD_WIDTH, IMG_HEIGHT));
  localparam logic [ADDR_W-1:0] CEND_A       = ADDR_W'(calc_end_addr(CENTER_WIDTH, IMG_HEIGHT));

  logic [1:0]        third_d, third_q;
  logic [ADDR_W-1:0] address_d, address_q;
  logic [ADDR_W-1:0] words_per_row, word_base, end_addr, col_word, row_ext;

  // Thirds are 16-aligned, so the row-global word index minus the third's first word gives lc/16.
  assign col_word = ADDR_W'(col_i[COL_W-1:4]);
  assign row_ext  = ADDR_W'(row_i);

  always_comb begin
    third_d       = THIRD_LEFT;
    words_per_row = THIRD_WORDS;
    word_base     = '0;
    end_addr      = TEND_A;
    if (col_i >= RIGHT_START) begin
      third_d   = THIRD_RIGHT;
      word_base = RIGHT_WORD0;
    end else if (col_i >= CENTER_START) begin
      third_d       = THIRD_CENTER;
      words_per_row = CENTER_WORDS;
      word_base     = THIRD_WORDS;
      end_addr      = CEND_A;
    end
    address_d = row_ext * words_per_row + (col_word - word_base) + (buf_idx_i ? end_addr : '0);
  end

  always_ff @(posedge clk50) begin
    if (!reset) begin
      third_q   <= THIRD_LEFT;
      address_q <= '0;
    end else if (load_i) begin
      third_q   <= third_d;
      address_q <= address_d;
    end
  end

  assign third_o   = third_q;
  assign address_o = address_q;

endmodule

// File: rtl/bit_pix_row_packer.sv
// rtl/bit_pix_row_packer.sv - packs a 1-bit raster stream into 16-bit BRAM words per third, ping-pong buffered
// Optional BIT_PIX_TEST_PATTERN_EN adds tp_enable, substituting col[3]^row[0] for pix_bit.
module bit_pix_row_packer
  import bit_pix_pkg::*;
#(
  parameter int THIRD_WIDTH  = DEF_THIRD_WIDTH,
  parameter int CENTER_WIDTH = DEF_CENTER_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int ADDR_W       = 16
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic              pix_bit,
  input  logic              pix_sof,
`ifdef BIT_PIX_TEST_PATTERN_EN
  input  logic              tp_enable,
`endif
  output logic [ADDR_W-1:0] wr_address,
  output logic [1:0]        wr_third,
  output logic [15:0]       wr_writedata,
  output logic              wr_write,
  output logic [31:0]       image_number,
  output logic              frame_done,
  output logic [7:0]        sync_err_cnt
);

  localparam int ROW_W_L  = calc_row_w(THIRD_WIDTH, CENTER_WIDTH);
  localparam int COL_W    = $clog2(ROW_W_L + 1);
  localparam int ROW_BITS = $clog2(IMG_HEIGHT + 1);
  localparam logic [COL_W-1:0]    LAST_COL = COL_W'(ROW_W_L - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);

  pack_state_e         state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d, pos_col;
  logic [ROW_BITS-1:0] row_q, row_d, pos_row;
  logic [15:0]         sr_q, sr_d, sr_base, sr_next;
  logic                buf_idx_q, buf_idx_d;
  logic [31:0]         image_number_q, image_number_d;
  logic [7:0]          sync_err_cnt_q, sync_err_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                wr_write_q, wr_write_d;
  logic [15:0]         wr_writedata_q, wr_writedata_d;
  logic                restart, accept, word_done, pix_in;

  // Any SOF pixel (re)starts a frame at (0,0); outside RUN only SOF pixels are taken.
  assign restart = pix_valid & pix_sof;
  assign accept  = pix_valid & ((state_q == RUN) | pix_sof);
  assign pos_col = restart ? '0 : col_q;
  assign pos_row = restart ? '0 : row_q;

`ifdef BIT_PIX_TEST_PATTERN_EN
  assign pix_in = tp_enable ? (pos_col[3] ^ pos_row[0]) : pix_bit;
`else
  assign pix_in = pix_bit;
`endif

  assign sr_base   = restart ? 16'h0000 : sr_q;
  assign sr_next   = {pix_in, sr_base[15:1]};
  assign word_done = accept & (pos_col[3:0] == 4'hF);

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    sr_d           = sr_q;
    buf_idx_d      = buf_idx_q;
    image_number_d = image_number_q;
    sync_err_cnt_d = sync_err_cnt_q;
    frame_done_d   = 1'b0;
    wr_write_d     = 1'b0;
    wr_writedata_d = wr_writedata_q;

    case (state_q)
      RUN: begin
        if (restart && (col_q != '0 || row_q != '0) && sync_err_cnt_q != 8'hFF)
          sync_err_cnt_d = sync_err_cnt_q + 8'd1;
      end
      DONE: begin
        frame_done_d   = 1'b1;
        image_number_d = image_number_q + 32'd1;
        buf_idx_d      = ~buf_idx_q;
        state_d        = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      sr_d    = sr_next;
      state_d = RUN;
      col_d   = pos_col + COL_W'(1);
      row_d   = pos_row;
      if (word_done) begin
        wr_write_d     = 1'b1;
        wr_writedata_d = sr_next;
      end
      if (pos_col == LAST_COL) begin
        col_d = '0;
        if (pos_row == LAST_ROW) begin
          row_d   = '0;
          state_d = DONE;
        end else begin
          row_d = pos_row + ROW_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (!reset) begin
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      sr_q           <= '0;
      buf_idx_q      <= 1'b0;
      image_number_q <= '0;
      sync_err_cnt_q <= '0;
      frame_done_q   <= 1'b0;
      wr_write_q     <= 1'b0;
      wr_writedata_q <= '0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      sr_q           <= sr_d;
      buf_idx_q      <= buf_idx_d;
      image_number_q <= image_number_d;
      sync_err_cnt_q <= sync_err_cnt_d;
      frame_done_q   <= frame_done_d;
      wr_write_q     <= wr_write_d;
      wr_writedata_q <= wr_writedata_d;
    end
  end

  bit_pix_addr_gen #(
    .THIRD_WIDTH (THIRD_WIDTH),
    .CENTER_WIDTH(CENTER_WIDTH),
    .IMG_HEIGHT  (IMG_HEIGHT),
    .ADDR_W      (ADDR_W),
    .COL_W       (COL_W),
    .ROW_BITS    (ROW_BITS)
  ) u_addr_gen (
    .clk50    (clk50),
    .reset    (reset),
    .load_i   (word_done),
    .col_i    (pos_col),
    .row_i    (pos_row),
    .buf_idx_i(buf_idx_q),
    .third_o  (wr_third),
    .address_o(wr_address)
  );

  assign wr_writedata = wr_writedata_q;
  assign wr_write     = wr_write_q;
  assign image_number = image_number_q;
  assign frame_done   = frame_done_q;
  assign sync_err_cnt = sync_err_cnt_q;

endmodule
